// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Read-side initiator for a synchronous BRAM port (1-cycle read latency).
//   Fetches a programmed run of consecutive words (base_addr, length) and
//   presents them as a valid/ready stream with a last-word marker. Never
//   writes the BRAM.
//
//   Optional feature macro: BRAM_STREAM_READER_LOOP_EN
//     When defined, adds input 'loop': if loop=1 when the last word of a pass
//     is issued, the run restarts at base_addr with the original length and
//     the FSM stays in RUN. Each pass still ends with out_last; done pulses
//     only when a pass completes with loop=0. abort is the only other exit.
//
// Ports
//   clk, rst        single clock, asynchronous active-high reset
//   start           launch a run (sampled in IDLE only)
//   abort           cancel current run; wins over everything
//   base_addr       first address of the run (sampled with start)
//   length          words in run, 0..2**ADDR_WIDTH (sampled with start)
//   mem_en/mem_wr   BRAM read strobe / write enable (always 0)
//   mem_addr        BRAM read address
//   mem_data        BRAM read data, valid the cycle after mem_en
//   out_valid/out_ready/out_data/out_last   output stream
//   busy            high while not IDLE
//   done            1-cycle pulse when a run completes normally

module bram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
`ifdef BRAM_STREAM_READER_LOOP_EN
    input  logic                  loop,
`endif
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    // vld_pipe[0] : read presented to the BRAM this cycle (== mem_en)
    // vld_pipe[1] : read data present on mem_data this cycle
    localparam int STAGES     = 1;
    localparam int FIFO_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    // Run bookkeeping
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   len_q;

    // Read pipeline tracking
    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] last_pipe;

    // Output FIFO
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            fifo_cnt;

    logic                  loop_en;
    logic                  abort_act;
    logic                  push;
    logic                  pop;
    logic                  room;
    logic [2:0]            committed;
    logic                  issue;
    logic                  issue_last;
    logic                  done_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] cur_base;
    logic [ADDR_WIDTH:0]   cur_rem;
    logic [ADDR_WIDTH:0]   cur_len;

`ifdef BRAM_STREAM_READER_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign mem_en    = vld_pipe[0];
    assign mem_wr    = 1'b0;
    assign busy      = (state != IDLE);
    assign abort_act = abort & (state != IDLE);

    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid & fifo_last[rd_ptr];

    assign pop  = out_valid & out_ready;
    assign push = vld_pipe[STAGES] & ~abort_act;

    // Words already promised to the FIFO (stored + in flight) after this
    // cycle's pop. A new read is only launched if it still fits, so the
    // 3-entry FIFO can never overflow regardless of out_ready.
    assign committed = {1'b0, fifo_cnt} + {2'b0, vld_pipe[0]}
                     + {2'b0, vld_pipe[1]} - {2'b0, pop};
    assign room      = (committed < 3'd3);

    // The first read is launched straight from IDLE so mem_en rises the
    // cycle after start; in that cycle the run parameters come from the
    // input ports rather than the latched copies.
    always_comb begin
        if (state == IDLE) begin
            cur_addr = base_addr;
            cur_base = base_addr;
            cur_rem  = length;
            cur_len  = length;
        end else begin
            cur_addr = addr_q;
            cur_base = base_q;
            cur_rem  = remaining;
            cur_len  = len_q;
        end
    end

    // Next-state and issue control
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        done_nxt   = 1'b0;
        issue_last = (cur_rem == (ADDR_WIDTH+1)'(1));
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (length == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        issue     = 1'b1;
                        state_nxt = (issue_last && !loop_en) ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                if ((remaining != '0) && room) begin
                    issue = 1'b1;
                    if (issue_last && !loop_en)
                        state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Final word handed over: every read has landed and drained.
                if (pop && out_last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_act) begin
            state_nxt = IDLE;
            issue     = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Address generation and read pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            base_q    <= '0;
            remaining <= '0;
            len_q     <= '0;
            mem_addr  <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
            done      <= 1'b0;
        end else begin
            done      <= done_nxt;
            // Abort drops the read whose data would land next cycle.
            vld_pipe  <= {vld_pipe[STAGES-1:0] & {STAGES{~abort_act}}, issue};
            last_pipe <= {last_pipe[STAGES-1:0], issue & issue_last};
            if (state == IDLE && start && !abort) begin
                base_q <= base_addr;
                len_q  <= length;
            end
            if (issue) begin
                mem_addr <= cur_addr;
                if (issue_last && loop_en) begin
                    addr_q    <= cur_base;
                    remaining <= cur_len;
                end else begin
                    // Wraps modulo 2**ADDR_WIDTH by width truncation.
                    addr_q    <= cur_addr + 1'b1;
                    remaining <= cur_rem - 1'b1;
                end
            end
        end
    end

    // Output FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            fifo_last <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_data[i] <= '0;
        end else if (abort_act) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_data;
                fifo_last[wr_ptr] <= last_pipe[STAGES];
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule
